// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the tx_arbiter slice: FSM state encoding,
// serializer mode values and data widths.
package tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_DONE,
      RELEASE
   } state_t;

   localparam logic MODE_WORD = 1'b0;
   localparam logic MODE_BYTE = 1'b1;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: returns the first set request bit
// searching from last+1 upward with wrap-around.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last,
   output logic             valid,
   output logic [IW-1:0]    index
);

   always_comb begin
      int k;
      valid = 1'b0;
      index = '0;
      k     = 0;
      // Offset 1 is the highest priority, offset N_REQ (last itself) the lowest.
      for (int i = 1; i <= N_REQ; i++) begin
         k = int'(last) + i;
         if (k >= N_REQ) k = k - N_REQ;
         if (!valid && req[k]) begin
            valid = 1'b1;
            index = k[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one word_to_byte_tx serializer between N_REQ
// requesters. Optional watchdog on the serializer done: TX_ARB_TIMEOUT_EN.
module tx_arbiter
   import tx_arb_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          req_mode,
   input  logic [WORD_W*N_REQ-1:0]   req_word,
   input  logic [BYTE_W*N_REQ-1:0]   req_byte,
   output logic [N_REQ-1:0]          ack,
   output logic                      err,
   output logic                      busy,
   output logic [$clog2(N_REQ)-1:0]  grant_id,
   output logic                      tx_enable,
   output logic                      tx_mode_select,
   output logic [WORD_W-1:0]         tx_word,
   output logic [BYTE_W-1:0]         tx_byte,
   input  logic                      tx_done
);

   localparam int IW = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
   end

   state_t        state;
   logic [IW-1:0] last;
   logic          pick_valid;
   logic [IW-1:0] pick_idx;

`ifdef TX_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wd_cnt;
   logic          err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_rr_pick (
      .req   (req),
      .last  (last),
      .valid (pick_valid),
      .index (pick_idx)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         last           <= IW'(N_REQ - 1);
         ack            <= '0;
         busy           <= 1'b0;
         grant_id       <= '0;
         tx_enable      <= 1'b0;
         tx_mode_select <= MODE_WORD;
         tx_word        <= '0;
         tx_byte        <= '0;
`ifdef TX_ARB_TIMEOUT_EN
         wd_cnt         <= '0;
         err_q          <= 1'b0;
`endif
      end else begin
         ack <= '0;
`ifdef TX_ARB_TIMEOUT_EN
         err_q <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               // Requester data is captured only here; later changes are ignored.
               if (pick_valid) begin
                  state          <= LAUNCH;
                  busy           <= 1'b1;
                  grant_id       <= pick_idx;
                  last           <= pick_idx;
                  tx_mode_select <= req_mode[pick_idx];
                  tx_word        <= req_word[int'(pick_idx)*WORD_W +: WORD_W];
                  tx_byte        <= req_byte[int'(pick_idx)*BYTE_W +: BYTE_W];
               end
            end
            LAUNCH: begin
               // Setup cycle: any done still high from a prior transfer is not sampled.
               state     <= WAIT_DONE;
               tx_enable <= 1'b1;
`ifdef TX_ARB_TIMEOUT_EN
               wd_cnt    <= '0;
`endif
            end
            WAIT_DONE: begin
               if (tx_done) begin
                  state         <= RELEASE;
                  tx_enable     <= 1'b0;
                  ack[grant_id] <= 1'b1;
               end
`ifdef TX_ARB_TIMEOUT_EN
               else if (wd_cnt == CW'(TIMEOUT_CYCLES)) begin
                  state         <= RELEASE;
                  tx_enable     <= 1'b0;
                  ack[grant_id] <= 1'b1;
                  err_q         <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
`endif
            end
            RELEASE: begin
               if (!tx_done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               tx_enable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: reset state, word and byte transfers,
// stale done, input change after grant, async reset, round-robin contention.
module tb_tx_arbiter;

   localparam int N = 4;

   logic           clock    = 1'b0;
   logic           reset_n  = 1'b0;
   logic [N-1:0]   req      = '0;
   logic [N-1:0]   req_mode = '0;
   logic [32*N-1:0] req_word = '0;
   logic [8*N-1:0] req_byte = '0;
   logic           tx_done  = 1'b0;

   logic [N-1:0]   ack;
   logic           err;
   logic           busy;
   logic [1:0]     grant_id;
   logic           tx_enable;
   logic           tx_mode_select;
   logic [31:0]    tx_word;
   logic [7:0]     tx_byte;

   int total = 0;
   int bad   = 0;
   int lows;

   tx_arbiter #(
      .N_REQ          (N),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .req            (req),
      .req_mode       (req_mode),
      .req_word       (req_word),
      .req_byte       (req_byte),
      .ack            (ack),
      .err            (err),
      .busy           (busy),
      .grant_id       (grant_id),
      .tx_enable      (tx_enable),
      .tx_mode_select (tx_mode_select),
      .tx_word        (tx_word),
      .tx_byte        (tx_byte),
      .tx_done        (tx_done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Bounded wait for tx_enable; lows counts the low cycles observed.
   task automatic wait_en(output int n_low);
      n_low = 0;
      while (!tx_enable && n_low < 20) begin
         tick();
         if (!tx_enable) n_low++;
      end
      if (!tx_enable) chk("en_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      // Reset state
      #12;
      chk("rst_ack", ack, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_en", tx_enable, 0);
      chk("rst_word", tx_word, 0);
      chk("rst_byte", tx_byte, 0);
      chk("rst_gid", grant_id, 0);
      reset_n = 1'b1;
      tick();

      // Single word transfer, then input change after grant
      req_word[31:0] = 32'h00ff90af;
      req = 4'b0001;
      tick();
      chk("w_launch_en", tx_enable, 0);
      chk("w_busy", busy, 1);
      chk("w_word", tx_word, 32'h00ff90af);
      chk("w_gid", grant_id, 0);
      tick();
      chk("w_en", tx_enable, 1);
      chk("w_mode", tx_mode_select, 0);
      req_word[31:0] = 32'hdeadbeef;
      tick();
      tick();
      chk("w_hold", tx_word, 32'h00ff90af);
      chk("w_noack", ack, 0);
      tx_done = 1'b1;
      tick();
      chk("w_ack", ack, 4'b0001);
      chk("w_en_low", tx_enable, 0);
      req = '0;
      tx_done = 1'b0;
      tick();
      chk("w_ack_pulse", ack, 0);
      chk("w_idle", busy, 0);

      // Byte mode with a stale done present during LAUNCH
      req_mode = 4'b0100;
      req_byte[23:16] = 8'hcd;
      req = 4'b0100;
      tick();
      chk("b_gid", grant_id, 2);
      chk("b_byte", tx_byte, 8'hcd);
      chk("b_mode", tx_mode_select, 1);
      tx_done = 1'b1;
      tick();
      chk("b_stale_en", tx_enable, 1);
      chk("b_stale_ack", ack, 0);
      tick();
      chk("b_ack", ack, 4'b0100);
      tick();
      chk("b_hold_busy", busy, 1);
      chk("b_ack_once", ack, 0);
      req = '0;
      tx_done = 1'b0;
      tick();
      chk("b_idle", busy, 0);
      req_mode = '0;

      // Reset during WAIT_DONE (last=2, so requester 1 wins via 3,0,1)
      req = 4'b0010;
      tick();
      tick();
      chk("r_en", tx_enable, 1);
      chk("r_gid", grant_id, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("r_en_drop", tx_enable, 0);
      chk("r_busy_drop", busy, 0);
      chk("r_noack", ack, 0);
      req = '0;
      #3;
      reset_n = 1'b1;
      tick();
      chk("r_stay_idle", busy, 0);

      // Contention: all four held, each drops on its ack
      req_word = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00ff90af};
      req = 4'b1111;
      for (int g = 0; g < N; g++) begin
         wait_en(lows);
         chk("c_gid", grant_id, g);
         chk("c_word", tx_word, req_word[32*g +: 32]);
         if (g > 0) chk("c_gap", lows + 2, 3);
         tick();
         tx_done = 1'b1;
         tick();
         chk("c_ack", ack, 64'd1 << g);
         chk("c_err", err, 0);
         req[g] = 1'b0;
         tx_done = 1'b0;
         tick();
         chk("c_ack_once", ack, 0);
         chk("c_en_low", tx_enable, 0);
      end
      tick();
      chk("c_done_idle", busy, 0);

`ifdef TX_ARB_TIMEOUT_EN
      // Watchdog: done never arrives; ack+err 17 cycles after WAIT_DONE entry
      req = 4'b0011;
      wait_en(lows);
      chk("t_gid", grant_id, 0);
      for (int i = 0; i < 16; i++) tick();
      chk("t_not_yet", ack, 0);
      tick();
      chk("t_ack", ack, 4'b0001);
      chk("t_err", err, 1);
      req[0] = 1'b0;
      tick();
      chk("t_err_pulse", err, 0);
      tick();
      chk("t_next_gid", grant_id, 1);
      req = '0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Shares the single word_to_byte_tx serializer between N_REQ requesters using round-robin arbitration.
- Latches the winning requester's mode, word and byte, then sequences the serializer's enable.
- Waits for the serializer's done signal and returns a one-cycle ack to the owner.
- Sits between the application-side producers (sensor, command, status paths) and the UART TX pin.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1048576, watchdog limit in clock cycles; used only with TX_ARB_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level; held until ack.
- req_mode  in  N_REQ  per-requester mode: 0 = 32-bit word, 1 = single byte.
- req_word  in  32*N_REQ  packed words; requester k occupies bits [32k+31:32k].
- req_byte  in  8*N_REQ  packed bytes; requester k occupies bits [8k+7:8k].
- ack  out  N_REQ  one-cycle completion pulse to the owner.
- err  out  1  one-cycle pulse with ack on timeout; constant 0 without the macro.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  $clog2(N_REQ)  current or last owner.
- tx_enable  out  1  to serializer enable.
- tx_mode_select  out  1  to serializer i_mode_select.
- tx_word  out  32  to serializer i_word.
- tx_byte  out  8  to serializer i_byte.
- tx_done  in  1  from serializer o_done.

Behaviour:
- Reset (async, all outputs registered):
  - state=IDLE; ack=0; err=0; busy=0; tx_enable=0; tx_mode_select=0; tx_word=0; tx_byte=0; grant_id=0.
  - RR pointer last=N_REQ-1, so requester 0 wins first.
- States: IDLE, LAUNCH, WAIT_DONE, RELEASE.
- IDLE:
  - If any req is high, pick the first set bit searching last+1, last+2, ... with wrap.
  - Register grant_id, last, and that requester's mode/word/byte into tx_*. Go to LAUNCH.
  - If no req is high, stay in IDLE.
- LAUNCH (1 cycle):
  - tx_* stable, tx_enable=0 (setup cycle).
  - Next state WAIT_DONE with tx_enable=1.
- WAIT_DONE:
  - tx_enable held at 1; tx_* held constant.
  - On the first cycle tx_done is sampled high, go to RELEASE.
- RELEASE:
  - tx_enable=0. ack[grant_id] pulses on the first RELEASE cycle only.
  - Stay in RELEASE while tx_done is high; go to IDLE once tx_done is low.
  - No arbitration happens in RELEASE.
- Latency: req seen at cycle t → LAUNCH at t+1 → tx_enable rises at t+2. tx_done at d → ack at d+1 → earliest IDLE at d+2 → next tx_enable at d+4.
- Data capture: requester inputs are latched only in IDLE. Changes after grant are ignored.
- Request withdrawal: dropping req before grant withdraws the request. Dropping req after grant has no effect, and ack is still issued.
- Requester rules: must drop req within one cycle after ack, otherwise it re-enters arbitration at lowest priority.
- Simultaneous requests: round-robin ordering guarantees no requester waits more than N_REQ-1 transfers.
- Stale done: tx_done already high in LAUNCH is ignored; only WAIT_DONE samples it.
- Reset mid-transfer: tx_enable drops asynchronously; no ack is issued.

Optional Feature:
- Macro: TX_ARB_TIMEOUT_EN.
- Defined:
  - Counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering WAIT_DONE and increments each WAIT_DONE cycle.
  - At TIMEOUT_CYCLES it forces RELEASE; ack[grant_id] and err pulse together.
  - tx_done arriving in the same cycle as the limit wins: normal ack, err=0.
- Not defined: no counter; WAIT_DONE waits indefinitely; err tied 0.

Decomposition:
- Package tx_arb_pkg holds:
  - state enum {IDLE, LAUNCH, WAIT_DONE, RELEASE}.
  - MODE_WORD=1'b0, MODE_BYTE=1'b1.
  - WORD_W=32, BYTE_W=8.
- Sub-module rr_pick: combinational rotate-priority-encoder.
  - Inputs: req vector, last pointer.
  - Outputs: valid, index.
  - Instantiated once.

Test Plan:
- Single word: req[0]=1, mode 0, word 32'h00ff90af.
  - → tx_enable rises 2 cycles later with tx_word=00ff90af and tx_mode_select=0.
  - → ack[0] one cycle after tx_done; busy low after.
- Contention: req=4'b1111 held, each dropped on its ack.
  - → grant order 0,1,2,3; each ack exactly once; tx_enable low for at least 3 cycles between transfers.
- Byte mode: req[2]=1, mode 1, byte 8'hcd → tx_byte=cd, tx_mode_select=1, ack[2] only.
- Input change after grant: req_word[0] changed to 32'hdeadbeef in WAIT_DONE → tx_word stays 00ff90af.
- Reset during WAIT_DONE → tx_enable and busy drop immediately; no ack; after release, requester 0 wins first again.
- TX_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and tx_done never asserted → ack[g] and err pulse together 17 cycles after WAIT_DONE entry; next requester then granted.
